sync_cmd_ctrl: RTL and testbench

- Command sequencer behind the DataSynchronization stage.
- Consumes the synchronized byte stream (enable pulse plus data) and parses write and read frames.
- Drives register-file write/read strobes and returns read data to the TX side over a valid/ready handshake.
- Frame timeout, unknown-command and overrun detection keep the parser from locking up on a broken stream.

---
 rtl/sync_cmd_ctrl_pkg.sv | 29 ++
 rtl/sync_cmd_ctrl_if.sv | 37 +++
 rtl/sync_cmd_ctrl_frame_timer.sv | 30 +++
 rtl/sync_cmd_ctrl.sv | 159 +++++++++++++++
 tb/tb_sync_cmd_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sync_cmd_ctrl_pkg.sv
// Shared types and constants for the command sequencer: state encodings,
// default opcodes and the frame-timer width helper.
package sync_ctrl_pkg;

    localparam logic [2:0] ENC_IDLE    = 3'd0;
    localparam logic [2:0] ENC_WR_ADDR = 3'd1;
    localparam logic [2:0] ENC_WR_DATA = 3'd2;
    localparam logic [2:0] ENC_RD_ADDR = 3'd3;
    localparam logic [2:0] ENC_RD_WAIT = 3'd4;
    localparam logic [2:0] ENC_TX_HOLD = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = ENC_IDLE,
        ST_WR_ADDR = ENC_WR_ADDR,
        ST_WR_DATA = ENC_WR_DATA,
        ST_RD_ADDR = ENC_RD_ADDR,
        ST_RD_WAIT = ENC_RD_WAIT,
        ST_TX_HOLD = ENC_TX_HOLD
    } state_t;

    localparam logic [7:0] CMD_WR = 8'hAA;
    localparam logic [7:0] CMD_RD = 8'hBB;

    // Enough bits to count 0 .. cycles-1; the counter saturates, never wraps.
    function automatic int timer_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/sync_cmd_ctrl_if.sv
// Byte-stream, register-file and TX handshake bundle around the command sequencer.
// master = sequencer side, slave = surrounding synchronizer / register file / transmitter.
interface sync_cmd_ctrl_if #(
    parameter int data_width = 8,
    parameter int addr_width = 4
) ();

    logic                  enable_in;
    logic [data_width-1:0] data_in;

    logic                  rf_wr_en;
    logic                  rf_rd_en;
    logic [addr_width-1:0] rf_addr;
    logic [data_width-1:0] rf_wr_data;
    logic [data_width-1:0] rf_rd_data;
    logic                  rf_rd_valid;

    logic [data_width-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    logic                  frame_err;
    logic                  busy;

    modport master (
        input  enable_in, data_in, rf_rd_data, rf_rd_valid, tx_ready,
        output rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, tx_data, tx_valid,
               frame_err, busy
    );

    modport slave (
        output enable_in, data_in, rf_rd_data, rf_rd_valid, tx_ready,
        input  rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, tx_data, tx_valid,
               frame_err, busy
    );

endinterface

// File: rtl/sync_cmd_ctrl_frame_timer.sv
// Idle-cycle watchdog: counts while enabled, clears on request, flags the
// terminal count combinationally so the owner can act in the same cycle.
module frame_timer
    import sync_ctrl_pkg::*;
#(
    parameter int terminal = 1024
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int             W    = timer_width(terminal);
    localparam logic [W-1:0]   LAST = W'(terminal - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_in) begin
        if (rst_in || clr) begin
            cnt <= '0;
        end else if (en && (cnt != LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = en && (cnt == LAST);

endmodule

// File: rtl/sync_cmd_ctrl.sv
// Parses write (cmd,addr,data) and read (cmd,addr) frames from the synchronized
// byte stream, strobes the register file and hands read data to the transmitter.
module sync_cmd_ctrl
    import sync_ctrl_pkg::*;
#(
    parameter int                    data_width     = 8,
    parameter int                    addr_width     = 4,
    parameter int                    timeout_cycles = 1024,
    parameter logic [data_width-1:0] cmd_wr         = CMD_WR,
    parameter logic [data_width-1:0] cmd_rd         = CMD_RD
) (
    input  logic           clk_in,
    input  logic           rst_in,
    sync_cmd_ctrl_if.master bus
);

    state_t                state;
    logic                  wr_en_q;
    logic                  rd_en_q;
    logic [addr_width-1:0] addr_q;
    logic [data_width-1:0] wr_data_q;
    logic [data_width-1:0] tx_data_q;
    logic                  tx_valid_q;
    logic                  err_q;
    logic                  busy_q;

    logic timer_en;
    logic timer_clr;
    logic expired;

    // Timer runs only while a frame is being assembled or read data is awaited.
    always_comb begin
        timer_en = (state == ST_WR_ADDR) || (state == ST_WR_DATA) ||
                   (state == ST_RD_ADDR) || (state == ST_RD_WAIT);
    end

    // Any progress or state change restarts the idle count; a byte dropped as an
    // overrun in RD_WAIT is not progress.
    always_comb begin
        timer_clr = !timer_en || expired;
        if (state == ST_RD_WAIT) begin
            if (bus.rf_rd_valid) timer_clr = 1'b1;
        end else if (bus.enable_in) begin
            timer_clr = 1'b1;
        end
    end

    frame_timer #(
        .terminal (timeout_cycles)
    ) u_timer (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (expired)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= ST_IDLE;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            addr_q     <= '0;
            wr_data_q  <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.enable_in) begin
                        if (bus.data_in == cmd_wr) begin
                            state  <= ST_WR_ADDR;
                            busy_q <= 1'b1;
                        end else if (bus.data_in == cmd_rd) begin
                            state  <= ST_RD_ADDR;
                            busy_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_WR_ADDR: begin
                    if (bus.enable_in) begin
                        addr_q <= bus.data_in[addr_width-1:0];
                        state  <= ST_WR_DATA;
                    end else if (expired) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                        err_q  <= 1'b1;
                    end
                end
                ST_WR_DATA: begin
                    if (bus.enable_in) begin
                        wr_data_q <= bus.data_in;
                        wr_en_q   <= 1'b1;
                        state     <= ST_IDLE;
                        busy_q    <= 1'b0;
                    end else if (expired) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                        err_q  <= 1'b1;
                    end
                end
                ST_RD_ADDR: begin
                    if (bus.enable_in) begin
                        addr_q  <= bus.data_in[addr_width-1:0];
                        rd_en_q <= 1'b1;
                        state   <= ST_RD_WAIT;
                    end else if (expired) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                        err_q  <= 1'b1;
                    end
                end
                ST_RD_WAIT: begin
                    // Overrun byte is dropped but read data is still taken.
                    if (bus.enable_in) err_q <= 1'b1;
                    if (bus.rf_rd_valid) begin
                        tx_data_q  <= bus.rf_rd_data;
                        tx_valid_q <= 1'b1;
                        state      <= ST_TX_HOLD;
                    end else if (expired) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                        err_q  <= 1'b1;
                    end
                end
                ST_TX_HOLD: begin
                    if (bus.enable_in) err_q <= 1'b1;
                    if (bus.tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state      <= ST_IDLE;
                        busy_q     <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    tx_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rf_wr_en   = wr_en_q;
    assign bus.rf_rd_en   = rd_en_q;
    assign bus.rf_addr    = addr_q;
    assign bus.rf_wr_data = wr_data_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.frame_err  = err_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_sync_cmd_ctrl.sv
// Bench for sync_cmd_ctrl: directed vector table, multi-cycle corner sequences,
// then random traffic against a frame-level reference model.
module tb_sync_cmd_ctrl;
    import sync_ctrl_pkg::*;

    localparam int T = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sync_cmd_ctrl_if #(.data_width(8), .addr_width(4)) bus ();

    sync_cmd_ctrl #(
        .data_width     (8),
        .addr_width     (4),
        .timeout_cycles (T),
        .cmd_wr         (8'hAA),
        .cmd_rd         (8'hBB)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Output bundle {wr_en, rd_en, addr, wr_data, tx_valid, tx_data, frame_err, busy}
    typedef struct packed {
        logic        rst;
        logic        en;
        logic [7:0]  dat;
        logic        rdv;
        logic [7:0]  rdd;
        logic        rdy;
        logic [24:0] exp;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t V(input logic r, e, input logic [7:0] d, input logic v,
                               input logic [7:0] vd, input logic y,
                               input logic wr, rd, input logic [3:0] a,
                               input logic [7:0] wd, input logic tv,
                               input logic [7:0] td, input logic er, bz);
        vec_t x;
        x.rst = r; x.en = e; x.dat = d; x.rdv = v; x.rdd = vd; x.rdy = y;
        x.exp = {wr, rd, a, wd, tv, td, er, bz};
        return x;
    endfunction

    function automatic logic [24:0] outs();
        return {bus.rf_wr_en, bus.rf_rd_en, bus.rf_addr, bus.rf_wr_data,
                bus.tx_valid, bus.tx_data, bus.frame_err, bus.busy};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks the bytes of the open frame, whether a read is
    // outstanding, the pending TX word, and how many quiet cycles have elapsed.
    logic [7:0] frame[$];
    int         quiet;
    bit         rd_pend;
    logic       m_wr, m_rd, m_txv, m_err, m_busy;
    logic [3:0] m_addr;
    logic [7:0] m_wdat, m_txd;

    task automatic model_step();
        logic [7:0] b;
        m_wr  = 1'b0;
        m_rd  = 1'b0;
        m_err = 1'b0;
        if (rst) begin
            frame.delete();
            quiet = 0; rd_pend = 0;
            m_addr = '0; m_wdat = '0; m_txv = 1'b0; m_txd = '0;
        end else if (m_txv) begin
            if (bus.enable_in) m_err = 1'b1;
            if (bus.tx_ready)  m_txv = 1'b0;
        end else if (rd_pend) begin
            if (bus.enable_in) m_err = 1'b1;
            if (bus.rf_rd_valid) begin
                m_txv = 1'b1; m_txd = bus.rf_rd_data; rd_pend = 0;
            end else begin
                quiet = quiet + 1;
                if (quiet == T) begin m_err = 1'b1; rd_pend = 0; end
            end
        end else if (frame.size() != 0) begin
            if (bus.enable_in) begin
                frame.push_back(bus.data_in);
                quiet = 0;
                if (frame.size() == 2) begin b = frame[1]; m_addr = b[3:0]; end
                if (frame[0] == 8'hAA && frame.size() == 3) begin
                    m_wr = 1'b1; m_wdat = frame[2]; frame.delete();
                end else if (frame[0] == 8'hBB && frame.size() == 2) begin
                    m_rd = 1'b1; rd_pend = 1; frame.delete();
                end
            end else begin
                quiet = quiet + 1;
                if (quiet == T) begin m_err = 1'b1; frame.delete(); end
            end
        end else if (bus.enable_in) begin
            if (bus.data_in == 8'hAA || bus.data_in == 8'hBB) begin
                frame.push_back(bus.data_in); quiet = 0;
            end else begin
                m_err = 1'b1;
            end
        end
        m_busy = (frame.size() != 0) || rd_pend || m_txv;
    endtask

    function automatic logic [24:0] model_outs();
        return {m_wr, m_rd, m_addr, m_wdat, m_txv, m_txd, m_err, m_busy};
    endfunction

    task automatic step(input logic r, e, input logic [7:0] d, input logic v,
                        input logic [7:0] vd, input logic y);
        @(negedge clk);
        rst = r; bus.enable_in = e; bus.data_in = d;
        bus.rf_rd_valid = v; bus.rf_rd_data = vd; bus.tx_ready = y;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic byte_in(input logic [7:0] d);
        step(1'b0, 1'b1, d, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    endtask

    logic       r, e, v, y;
    logic [7:0] d, vd;
    int         sel;
    bit         sparse;

    initial begin
        bus.enable_in = 1'b0; bus.data_in = '0; bus.rf_rd_valid = 1'b0;
        bus.rf_rd_data = '0; bus.tx_ready = 1'b0;

        //           rst en dat   rdv rdd   rdy  wr rd a     wdat  tv td    er bz
        tbl[0]  = V(1, 0, 8'h00, 0, 8'h00, 0,  0, 0, 4'h0, 8'h00, 0, 8'h00, 0, 0);
        tbl[1]  = V(0, 1, 8'hAA, 0, 8'h00, 0,  0, 0, 4'h0, 8'h00, 0, 8'h00, 0, 1);
        tbl[2]  = V(0, 1, 8'h13, 0, 8'h00, 0,  0, 0, 4'h3, 8'h00, 0, 8'h00, 0, 1);
        tbl[3]  = V(0, 1, 8'h5C, 0, 8'h00, 0,  1, 0, 4'h3, 8'h5C, 0, 8'h00, 0, 0);
        tbl[4]  = V(0, 1, 8'h55, 0, 8'h00, 0,  0, 0, 4'h3, 8'h5C, 0, 8'h00, 1, 0);
        tbl[5]  = V(0, 1, 8'hBB, 0, 8'h00, 0,  0, 0, 4'h3, 8'h5C, 0, 8'h00, 0, 1);
        tbl[6]  = V(0, 1, 8'hF7, 0, 8'h00, 0,  0, 1, 4'h7, 8'h5C, 0, 8'h00, 0, 1);
        tbl[7]  = V(0, 0, 8'h00, 1, 8'h3E, 0,  0, 0, 4'h7, 8'h5C, 1, 8'h3E, 0, 1);
        tbl[8]  = V(0, 1, 8'h99, 0, 8'h00, 0,  0, 0, 4'h7, 8'h5C, 1, 8'h3E, 1, 1);
        tbl[9]  = V(0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 4'h7, 8'h5C, 0, 8'h3E, 0, 0);
        tbl[10] = V(0, 1, 8'hAA, 0, 8'h00, 0,  0, 0, 4'h7, 8'h5C, 0, 8'h3E, 0, 1);
        tbl[11] = V(0, 1, 8'h04, 0, 8'h00, 0,  0, 0, 4'h4, 8'h5C, 0, 8'h3E, 0, 1);
        tbl[12] = V(1, 0, 8'h00, 0, 8'h00, 0,  0, 0, 4'h0, 8'h00, 0, 8'h00, 0, 0);
        tbl[13] = V(0, 1, 8'h21, 0, 8'h00, 0,  0, 0, 4'h0, 8'h00, 0, 8'h00, 1, 0);
        tbl[14] = V(0, 1, 8'hBB, 0, 8'h00, 0,  0, 0, 4'h0, 8'h00, 0, 8'h00, 0, 1);
        tbl[15] = V(0, 1, 8'h02, 1, 8'h44, 0,  0, 1, 4'h2, 8'h00, 0, 8'h00, 0, 1);
        tbl[16] = V(0, 0, 8'h00, 1, 8'h66, 1,  0, 0, 4'h2, 8'h00, 1, 8'h66, 0, 1);
        tbl[17] = V(0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 4'h2, 8'h00, 0, 8'h66, 0, 0);
        tbl[18] = V(0, 1, 8'hAA, 0, 8'h00, 0,  0, 0, 4'h2, 8'h00, 0, 8'h66, 0, 1);
        tbl[19] = V(0, 1, 8'h01, 0, 8'h00, 0,  0, 0, 4'h1, 8'h00, 0, 8'h66, 0, 1);
        tbl[20] = V(0, 1, 8'hFF, 0, 8'h00, 0,  1, 0, 4'h1, 8'hFF, 0, 8'h66, 0, 0);

        for (int i = 0; i < 21; i++) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].dat, tbl[i].rdv, tbl[i].rdd, tbl[i].rdy);
            chk($sformatf("vec%0d", i), {7'd0, outs()}, {7'd0, tbl[i].exp});
        end

        // Write frame with 10-cycle gaps between bytes
        do_reset();
        byte_in(8'hAA);
        for (int i = 0; i < 10; i++) idle();
        byte_in(8'h03);
        for (int i = 0; i < 10; i++) idle();
        byte_in(8'h5C);
        chk("gap_write_strobe", {bus.rf_wr_en, bus.rf_addr, bus.rf_wr_data, bus.frame_err},
            {1'b1, 4'h3, 8'h5C, 1'b0});
        idle();
        chk("gap_write_single", {bus.rf_wr_en, bus.busy}, 2'b00);

        // Timeout: T quiet cycles after the address byte abort the frame
        do_reset();
        byte_in(8'hAA);
        byte_in(8'h02);
        for (int i = 0; i < T - 1; i++) begin
            idle();
            chk($sformatf("to_wait%0d", i), {bus.rf_wr_en, bus.frame_err, bus.busy}, 3'b001);
        end
        idle();
        chk("to_expire", {bus.rf_wr_en, bus.frame_err, bus.busy}, 3'b010);
        idle();
        chk("to_after", {bus.rf_wr_en, bus.frame_err, bus.busy}, 3'b000);

        // Data byte landing on the last allowed cycle still writes
        do_reset();
        byte_in(8'hAA);
        byte_in(8'h02);
        for (int i = 0; i < T - 1; i++) idle();
        byte_in(8'h5C);
        chk("to_late_write", {bus.rf_wr_en, bus.rf_addr, bus.rf_wr_data, bus.frame_err},
            {1'b1, 4'h2, 8'h5C, 1'b0});

        // Read with 5 cycles of TX backpressure plus an overrun byte
        do_reset();
        byte_in(8'hBB);
        byte_in(8'h07);
        chk("rd_strobe", {bus.rf_rd_en, bus.rf_addr}, {1'b1, 4'h7});
        idle();
        chk("rd_wait", {bus.rf_rd_en, bus.tx_valid, bus.busy}, 3'b001);
        step(1'b0, 1'b0, 8'h00, 1'b1, 8'h3E, 1'b0);
        chk("tx_hold0", {bus.tx_valid, bus.tx_data}, {1'b1, 8'h3E});
        for (int i = 1; i < 6; i++) begin
            step(1'b0, (i == 2), 8'h5A, 1'b0, 8'h00, 1'b0);
            chk($sformatf("tx_hold%0d", i), {bus.tx_valid, bus.tx_data, bus.frame_err},
                {1'b1, 8'h3E, (i == 2)});
        end
        step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        chk("tx_done", {bus.tx_valid, bus.busy, bus.frame_err}, 3'b000);

        // Random traffic against the reference model
        do_reset();
        chk("rand_reset", {7'd0, outs()}, {7'd0, model_outs()});
        for (int c = 0; c < 4000; c++) begin
            sparse = ((c / 250) % 2) == 1;
            r   = ($urandom_range(0, 299) == 0);
            e   = sparse ? ($urandom_range(0, 24) == 0) : ($urandom_range(0, 1) == 0);
            sel = $urandom_range(0, 9);
            d   = (sel < 4) ? 8'hAA : (sel < 7) ? 8'hBB : 8'($urandom);
            v   = ($urandom_range(0, 9) == 0);
            vd  = 8'($urandom);
            y   = ($urandom_range(0, 2) == 0);
            step(r, e, d, v, vd, y);
            chk("random", {7'd0, outs()}, {7'd0, model_outs()});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
